// File: rtl/gpio_aux_pkg.sv
// Shared definitions for the GPIO auxiliary blocks.
// Contents:
//   op_e    - command opcodes (WRITE/SET/CLEAR/TOGGLE/PULSE); 5-7 are illegal
//   state_e - output-sequencer states (IDLE/PULSE)
//   CNT_W   - pulse down-counter width (PULSE_CYCLES <= 65535)
package gpio_aux_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    OP_WRITE  = 3'd0,
    OP_SET    = 3'd1,
    OP_CLEAR  = 3'd2,
    OP_TOGGLE = 3'd3,
    OP_PULSE  = 3'd4
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_e;

endpackage

// File: rtl/gpio_aux_pulse_timer.sv
// Pulse-length down-counter with terminal-count flag.
// Ports:
//   sys_clk  in   clock
//   sys_rst  in   async active-high reset (counter -> 0)
//   load     in   load PULSE_CYCLES-1
//   count    in   decrement by one (holds at zero)
//   zero     out  counter is at terminal count
module gpio_aux_pulse_timer
  import gpio_aux_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 8
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic load,
  input  logic count,
  output logic zero
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gpio_aux_out.sv
// GPIO auxiliary output register with a small command interface.
// Commands WRITE/SET/CLEAR/TOGGLE modify aux_o on the accepting edge;
// PULSE inverts the masked bits for exactly PULSE_CYCLES clocks.
// Opcodes 5-7 (and 4 when pulses are not built) raise cmd_err for one cycle.
//
// Build option: define GPIO_AUX_OUT_PULSE_EN to include PULSE support.
// Without it, busy is tied 0 and cmd_ready tied 1.
//
// Ports:
//   sys_clk    in   clock
//   sys_rst    in   async active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted
//   cmd_op     in   opcode (see gpio_aux_pkg::op_e)
//   cmd_data   in   write value / bit mask
//   aux_o      out  registered GPIO auxiliary output
//   busy       out  pulse in progress
//   cmd_err    out  one-cycle illegal-opcode flag
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | ready for commands, no pulse active
// ST_PULSE | masked bits inverted, timer running, not ready
module gpio_aux_out
  import gpio_aux_pkg::*;
#(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   RST_VAL      = {WIDTH{1'b0}},
  parameter int unsigned        PULSE_CYCLES = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] aux_o,
  output logic             busy,
  output logic             cmd_err
);

  op_e              op;
  logic             is_alu;
  logic [WIDTH-1:0] alu_val;

  assign op = op_e'(cmd_op);

  always_comb begin
    is_alu  = 1'b1;
    alu_val = aux_o;
    case (op)
      OP_WRITE:  alu_val = cmd_data;
      OP_SET:    alu_val = aux_o | cmd_data;
      OP_CLEAR:  alu_val = aux_o & ~cmd_data;
      OP_TOGGLE: alu_val = aux_o ^ cmd_data;
      default:   is_alu  = 1'b0;
    endcase
  end

`ifdef GPIO_AUX_OUT_PULSE_EN

  state_e           state;
  logic [WIDTH-1:0] mask;
  logic             tmr_load;
  logic             tmr_count;
  logic             tmr_zero;
  logic             start_pulse;

  // cmd_ready is high exactly in ST_IDLE, so this is the accept condition
  assign start_pulse = cmd_valid && cmd_ready && (op == OP_PULSE);
  assign tmr_load    = start_pulse;
  assign tmr_count   = (state == ST_PULSE);

  gpio_aux_pulse_timer #(
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .load    (tmr_load),
    .count   (tmr_count),
    .zero    (tmr_zero)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      aux_o     <= RST_VAL;
      state     <= ST_IDLE;
      mask      <= '0;
      cmd_err   <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      cmd_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (is_alu) begin
              aux_o <= alu_val;
            end else if (op == OP_PULSE) begin
              aux_o     <= aux_o ^ cmd_data;
              mask      <= cmd_data;
              state     <= ST_PULSE;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        ST_PULSE: begin
          // Timer was loaded with PULSE_CYCLES-1, so this edge lands
          // exactly PULSE_CYCLES clocks after the inverting edge.
          if (tmr_zero) begin
            aux_o     <= aux_o ^ mask;
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`else

  assign cmd_ready = 1'b1;
  assign busy      = 1'b0;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      aux_o   <= RST_VAL;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (cmd_valid) begin
        if (is_alu) begin
          aux_o <= alu_val;
        end else begin
          cmd_err <= 1'b1;
        end
      end
    end
  end

`endif

endmodule

// File: tb/tb_gpio_aux_out.sv
module tb_gpio_aux_out;

  localparam logic [31:0] RV = 32'hA5A5_A5A5;
  localparam int          PC = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [31:0] aux_o;
  logic        busy;
  logic        cmd_err;

  int n_assert = 0;
  int n_fail   = 0;

  gpio_aux_out #(
    .WIDTH        (32),
    .RST_VAL      (RV),
    .PULSE_CYCLES (PC)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .aux_o     (aux_o),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pulse is described by the absolute cycle on which
  // it ends; the block is ready whenever no pulse is outstanding.
  int          cyc = 0;
  logic [31:0] m_aux = RV;
  logic [31:0] m_mask = 32'd0;
  logic        m_err = 1'b0;
  bit          m_in_pulse = 1'b0;
  int          pulse_end = 0;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_aux      = RV;
      m_err      = 1'b0;
      m_in_pulse = 1'b0;
      m_mask     = 32'd0;
    end else begin
      cyc++;
      m_err = 1'b0;
      if (!m_in_pulse) begin
        if (cmd_valid) begin
          case (cmd_op)
            3'd0: m_aux = cmd_data;
            3'd1: m_aux = m_aux | cmd_data;
            3'd2: m_aux = m_aux & ~cmd_data;
            3'd3: m_aux = m_aux ^ cmd_data;
`ifdef GPIO_AUX_OUT_PULSE_EN
            3'd4: begin
              m_aux      = m_aux ^ cmd_data;
              m_mask     = cmd_data;
              m_in_pulse = 1'b1;
              pulse_end  = cyc + PC;
            end
`endif
            default: m_err = 1'b1;
          endcase
        end
      end else if (cyc == pulse_end) begin
        m_aux      = m_aux ^ m_mask;
        m_in_pulse = 1'b0;
      end
    end
  end

  always @(negedge sys_clk) begin
    chk("cyc_aux",   aux_o,            m_aux);
    chk("cyc_ready", {31'd0, cmd_ready}, {31'd0, !m_in_pulse});
    chk("cyc_busy",  {31'd0, busy},      {31'd0, m_in_pulse});
    chk("cyc_err",   {31'd0, cmd_err},   {31'd0, m_err});
  end

  // Present a command and hold it until the edge on which it is accepted.
  task automatic issue(input logic [2:0] op, input logic [31:0] d, output int edges);
    bit rdy;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    edges     = 0;
    rdy       = 1'b0;
    while (!rdy) begin
      rdy = !m_in_pulse;
      @(posedge sys_clk); #1;
      edges++;
      if (edges > 100) begin
        chk("issue_timeout", 32'd0, 32'd1);
        rdy = 1'b1;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin
      @(posedge sys_clk); #1;
    end
  endtask

  initial begin
    int e;
    // reset with a command asserted: nothing may take effect
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_data  = 32'h1111_1111;
    #1 sys_rst = 1'b1;
    #2;
    chk("rst_aux_early", aux_o, RV);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    #7;
    chk("rst_aux_after_edge", aux_o, RV);
    chk("rst_err", {31'd0, cmd_err}, 32'd0);
    #3 sys_rst = 1'b0;
    cmd_valid = 1'b0;
    @(posedge sys_clk); #1;
    chk("rst_release_aux", aux_o, RV);

    // back-to-back ALU operations
    issue(3'd0, 32'h1234_5678, e); chk("write", aux_o, 32'h1234_5678);
    issue(3'd1, 32'hFF00_0000, e); chk("set",   aux_o, 32'hFF34_5678);
    issue(3'd2, 32'h0000_FFFF, e); chk("clear", aux_o, 32'hFF34_0000);
    issue(3'd3, 32'h00FF_0000, e); chk("toggle", aux_o, 32'hFFCB_0000);
    chk("toggle_latency", e, 32'd1);

    // illegal opcodes
    issue(3'd6, 32'hFFFF_FFFF, e);
    chk("ill6_aux", aux_o, 32'hFFCB_0000);
    chk("ill6_err", {31'd0, cmd_err}, 32'd1);
    idle(1);
    chk("ill6_err_drop", {31'd0, cmd_err}, 32'd0);
    issue(3'd7, 32'h0F0F_0F0F, e);
    chk("ill7_err", {31'd0, cmd_err}, 32'd1);
    idle(2);

`ifdef GPIO_AUX_OUT_PULSE_EN
    issue(3'd0, 32'h0, e);
    issue(3'd4, 32'hDEAD_BEEF, e);
    for (int k = 0; k < PC; k++) begin
      chk("pulse_aux",   aux_o, 32'hDEAD_BEEF);
      chk("pulse_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge sys_clk); #1;
    end
    chk("pulse_restore", aux_o, 32'h0);
    chk("pulse_ready_back", {31'd0, cmd_ready}, 32'd1);
    idle(1);

    // command held through a pulse is accepted on the first ready edge
    issue(3'd4, 32'h0000_FFFF, e);
    issue(3'd0, 32'h1234_5678, e);
    chk("held_write_edges", e, 32'd9);
    chk("held_write_aux", aux_o, 32'h1234_5678);

    // zero-mask pulse still occupies the full length
    issue(3'd4, 32'h0, e);
    chk("zero_mask_aux", aux_o, 32'h1234_5678);
    chk("zero_mask_busy", {31'd0, busy}, 32'd1);
    idle(PC + 2);

    // reset in the 3rd pulse cycle: no restore afterwards
    issue(3'd0, 32'h0, e);
    issue(3'd4, 32'hDEAD_BEEF, e);
    idle(2);
    sys_rst = 1'b1;
    #1;
    chk("midrst_aux",   aux_o, RV);
    chk("midrst_busy",  {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    idle(PC + 4);
    chk("midrst_no_restore", aux_o, RV);
`else
    // opcode 4 is illegal in this build
    issue(3'd4, 32'hFFFF_FFFF, e);
    chk("op4_aux",  aux_o, 32'hFFCB_0000);
    chk("op4_err",  {31'd0, cmd_err}, 32'd1);
    chk("op4_busy", {31'd0, busy}, 32'd0);
    idle(3);
    chk("op4_busy_later", {31'd0, busy}, 32'd0);

    // reset while running
    issue(3'd0, 32'h0000_0001, e);
    sys_rst = 1'b1;
    #1;
    chk("rst2_aux", aux_o, RV);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    idle(3);
    chk("rst2_hold", aux_o, RV);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_aux_out.md
GPIO_AUX_OUT -- requirements
Module: gpio_aux_out

Interface
REQ-001 SHALL have parameter WIDTH, default 32, output bus width.
REQ-002 SHALL have parameter RST_VAL, default 32'h0000_0000, aux_o value while in reset.
REQ-003 SHALL have parameter PULSE_CYCLES, default 8, pulse length in clocks; legal range 1..65535.
REQ-004 SHALL have port sys_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1, command present.
REQ-007 SHALL have port cmd_ready, output, 1, block can accept a command.
REQ-008 SHALL have port cmd_op, input, 3, opcode: 0 WRITE, 1 SET, 2 CLEAR, 3 TOGGLE, 4 PULSE, 5-7 illegal.
REQ-009 SHALL have port cmd_data, input, WIDTH, write value or bit mask.
REQ-010 SHALL have port aux_o, output, WIDTH, registered GPIO auxiliary output.
REQ-011 SHALL have port busy, output, 1, high while a pulse is in progress.
REQ-012 SHALL have port cmd_err, output, 1, one-cycle flag for an illegal opcode.

Function
REQ-013 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both high; no other edge has any effect from cmd_*.
REQ-014 SHALL update aux_o on the accepting edge: WRITE gives aux_o = data; SET gives aux_o | data; CLEAR gives aux_o & ~data; TOGGLE gives aux_o ^ data. New value is visible one cycle after the command is presented.
REQ-015 SHALL implement FSM states IDLE and PULSE; IDLE sets cmd_ready=1 and busy=0; PULSE sets cmd_ready=0 and busy=1.
REQ-016 SHALL, on accepting PULSE in IDLE, set aux_o ^= data, latch the mask, load counter = PULSE_CYCLES-1, and enter PULSE.
REQ-017 SHALL, in PULSE, decrement the counter each cycle; when counter==0, set aux_o ^= latched mask and return to IDLE, so masked bits stay inverted for exactly PULSE_CYCLES cycles.
REQ-018 SHALL treat PULSE with mask 0 as a normal pulse: it still occupies PULSE_CYCLES cycles and aux_o does not change.
REQ-019 SHALL accept an illegal opcode (5-7) without changing aux_o, and assert cmd_err for exactly the following cycle.
REQ-020 SHALL hold cmd_valid pending while cmd_ready=0 and drop nothing; a command presented in the last PULSE cycle is accepted on the first IDLE edge.
REQ-021 SHALL keep cmd_err low at all times except as set by REQ-019.

Reset
REQ-022 SHALL, while sys_rst=1, asynchronously force aux_o=RST_VAL, FSM=IDLE, counter=0, mask=0, cmd_err=0, busy=0, cmd_ready=1.
REQ-023 SHALL abort an active pulse when reset is asserted: aux_o goes to RST_VAL with no restore step.
REQ-024 SHALL resume normal operation on the first rising edge after sys_rst deasserts.

Configuration
REQ-025 SHALL compile PULSE support only when the macro GPIO_AUX_OUT_PULSE_EN is defined.
REQ-026 SHALL, without GPIO_AUX_OUT_PULSE_EN, treat opcode 4 as illegal per REQ-019, omit the counter, mask and PULSE state, and tie busy=0 and cmd_ready=1.

Structure
REQ-027 SHALL take the opcode enum (WRITE/SET/CLEAR/TOGGLE/PULSE) and the FSM state enum from shared package gpio_aux_pkg; gpio_aux_in also imports this package.
REQ-028 SHALL place the pulse down-counter in sub-module gpio_aux_pulse_timer (inputs load and count; outputs zero), instantiated only under GPIO_AUX_OUT_PULSE_EN.

Verification
REQ-029 Reset: assert sys_rst for 12 ns with RST_VAL=32'hA5A5A5A5 and cmd_valid=1 -> aux_o=A5A5A5A5 throughout; no command takes effect.
REQ-030 ALU ops: WRITE 12345678, SET FF000000, CLEAR 0000FFFF, TOGGLE 00FF0000 -> aux_o is 12345678, FF345678, FF340000, FFCB0000 on consecutive cycles.
REQ-031 Pulse: aux_o=0, PULSE mask DEADBEEF, PULSE_CYCLES=8 -> aux_o=DEADBEEF for exactly 8 cycles then 0; cmd_ready low for 8 cycles; a back-to-back WRITE is accepted on the first ready edge.
REQ-032 Reset mid-pulse: assert sys_rst on the 3rd pulse cycle -> aux_o=RST_VAL, busy=0, cmd_ready=1 immediately; no restore XOR after release.
REQ-033 Illegal op: cmd_op=6, data FFFFFFFF -> aux_o unchanged and cmd_err high for one cycle; with the macro undefined, op 4 gives the same result and busy stays 0.
